arb_burst_requester: RTL and testbench

- Requester-side agent for the round-robin arbiter's req/hold/gnt interface; one instance per arbiter input.
- Buffers upstream beats and raises req only once a complete packet is held.
- Transfers the packet one beat per granted cycle and keeps hold asserted so the grant persists to the last beat.
- Sits between a client stream source and the shared bus mux driven by the arbiter's gnt.

---
 rtl/arb_burst_requester_if.sv | 32 +++
 rtl/arb_burst_requester.sv | 141 ++++++++++++++
 tb/tb_arb_burst_requester.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/arb_burst_requester_if.sv
// Purpose: requester-side handshake bundle: upstream beat stream, arbiter req/hold/gnt, registered bus beat, status.
// Latency: none; this file only groups the signals.
// Backpressure: in_ready throttles the upstream source, and gnt paces the beats driven onto the bus.
interface arb_burst_requester_if #(
   parameter int DATA_W = 32,
   parameter int CNT_W  = 4
);
   logic              in_valid;
   logic              in_ready;
   logic [DATA_W-1:0] in_data;
   logic              in_last;
   logic              req;
   logic              hold;
   logic              gnt;
   logic              bus_valid;
   logic [DATA_W-1:0] bus_data;
   logic              bus_last;
   logic [CNT_W-1:0]  fill;
   logic              err_deadlock;

   // Requester (the agent itself).
   modport master (
      input  in_valid, in_data, in_last, gnt,
      output in_ready, req, hold, bus_valid, bus_data, bus_last, fill, err_deadlock
   );

   // Surroundings: stream source, arbiter and bus monitor.
   modport slave (
      output in_valid, in_data, in_last, gnt,
      input  in_ready, req, hold, bus_valid, bus_data, bus_last, fill, err_deadlock
   );
endinterface

// File: rtl/arb_burst_requester.sv
// Purpose: buffers an upstream packet, then requests the arbiter and streams the packet with hold held until the last beat.
// Latency: a bus beat appears 1 cycle after its granted cycle; req rises the cycle after the last beat of a packet is pushed.
// Backpressure: in_ready = !full and does not depend on a same-cycle pop; a missing gnt stalls the burst with req/hold kept high.
module arb_burst_requester #(
   parameter int DATA_W = 32,
   parameter int DEPTH  = 8,
   parameter int CNT_W  = $clog2(DEPTH) + 1
) (
   input  logic                   clk,
   input  logic                   rst_b,
   arb_burst_requester_if.master  rq
);
   localparam int AW = $clog2(DEPTH);
   localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

   typedef enum logic {
      ST_IDLE = 1'b0,
      ST_XFER = 1'b1
   } state_t;

   state_t            state_q, state_d;
   logic [DATA_W:0]   mem_q [DEPTH];
   logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
   logic [CNT_W-1:0]  fill_q, fill_d;
   logic [CNT_W-1:0]  pkt_cnt_q, pkt_cnt_d;
   logic              err_q, err_d;
   logic              bus_valid_q;
   logic [DATA_W-1:0] bus_data_q;
   logic              bus_last_q;

   logic              full;
   logic              push;
   logic              pop;
   logic              req_w;
   logic              hold_w;
   logic [DATA_W:0]   head;
   logic              head_last;

   assign full      = (fill_q == FULL_CNT);
   assign push      = rq.in_valid & ~full;
   assign head      = mem_q[rd_ptr_q];
   assign head_last = head[DATA_W];

   // Request/transfer control: a packet is only requested once it is completely buffered, so a head beat always exists in XFER.
   always_comb begin
      state_d = state_q;
      req_w   = 1'b0;
      hold_w  = 1'b0;
      pop     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            req_w = (pkt_cnt_q != '0);
            pop   = req_w & rq.gnt;
            if (pop && !head_last) begin
               state_d = ST_XFER;
            end
         end
         ST_XFER: begin
            req_w  = 1'b1;
            hold_w = 1'b1;
            pop    = rq.gnt;
            if (pop && head_last) begin
               state_d = ST_IDLE;
            end
         end
         default: state_d = ST_IDLE;
      endcase
   end

   // Occupancy, complete-packet count and sticky deadlock flag for the next cycle.
   always_comb begin
      fill_d    = fill_q;
      pkt_cnt_d = pkt_cnt_q;
      err_d     = err_q | (full & (pkt_cnt_q == '0));
      case ({push, pop})
         2'b10:   fill_d = fill_q + CNT_W'(1);
         2'b01:   fill_d = fill_q - CNT_W'(1);
         default: fill_d = fill_q;
      endcase
      case ({push & rq.in_last, pop & head_last})
         2'b10:   pkt_cnt_d = pkt_cnt_q + CNT_W'(1);
         2'b01:   pkt_cnt_d = pkt_cnt_q - CNT_W'(1);
         default: pkt_cnt_d = pkt_cnt_q;
      endcase
   end

   // Beat storage; contents need no reset because the pointers and fill define validity.
   always_ff @(posedge clk) begin
      if (push) begin
         mem_q[wr_ptr_q] <= {rq.in_last, rq.in_data};
      end
   end

   // Control state, pointers and counters; reset discards every buffered beat.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         state_q   <= ST_IDLE;
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         fill_q    <= '0;
         pkt_cnt_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         fill_q    <= fill_d;
         pkt_cnt_q <= pkt_cnt_d;
         err_q     <= err_d;
         if (push) begin
            wr_ptr_q <= wr_ptr_q + AW'(1);
         end
         if (pop) begin
            rd_ptr_q <= rd_ptr_q + AW'(1);
         end
      end
   end

   // Registered bus beat: valid pulses per pop, payload holds its last value between pops.
   always_ff @(posedge clk or negedge rst_b) begin
      if (!rst_b) begin
         bus_valid_q <= 1'b0;
         bus_data_q  <= '0;
         bus_last_q  <= 1'b0;
      end else begin
         bus_valid_q <= pop;
         if (pop) begin
            bus_data_q <= head[DATA_W-1:0];
            bus_last_q <= head_last;
         end
      end
   end

   assign rq.in_ready     = ~full;
   assign rq.req          = req_w;
   assign rq.hold         = hold_w;
   assign rq.bus_valid    = bus_valid_q;
   assign rq.bus_data     = bus_data_q;
   assign rq.bus_last     = bus_last_q;
   assign rq.fill         = fill_q;
   assign rq.err_deadlock = err_q;

endmodule

// File: tb/tb_arb_burst_requester.sv
// Purpose: self-checking bench for arb_burst_requester against a queue-based packet model.
// Latency: model predicts bus beats 1 cycle after each granted cycle.
// Backpressure: stimulus only counts beats the model says were accepted; gnt is either random or tied to req.
module tb_arb_burst_requester;
   localparam int DW    = 32;
   localparam int DEPTH = 8;
   localparam int CW    = 4;

   logic clk   = 1'b0;
   logic rst_b = 1'b0;
   always #5 clk = ~clk;

   arb_burst_requester_if #(.DATA_W(DW), .CNT_W(CW)) bif();

   logic gnt_auto = 1'b0;
   logic gnt_man  = 1'b0;
   assign bif.gnt = gnt_auto ? bif.req : gnt_man;

   arb_burst_requester #(.DATA_W(DW), .DEPTH(DEPTH), .CNT_W(CW)) dut (
      .clk   (clk),
      .rst_b (rst_b),
      .rq    (bif.master)
   );

   int total = 0;
   int bad   = 0;

   task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
      end
   endtask

   // Behavioural model: a queue of beats, the number of complete packets queued,
   // and whether a packet is partly sent.
   logic [DW:0]   mq[$];
   int            m_pkts  = 0;
   bit            m_burst = 1'b0;
   bit            m_err   = 1'b0;
   bit            m_bv    = 1'b0;
   bit            m_bl    = 1'b0;
   logic [DW-1:0] m_bd    = '0;

   always @(posedge clk or negedge rst_b) begin
      int          sz;
      bit          want, g, pu, po;
      logic [DW:0] b;
      if (!rst_b) begin
         mq.delete();
         m_pkts  = 0;
         m_burst = 1'b0;
         m_err   = 1'b0;
         m_bv    = 1'b0;
         m_bl    = 1'b0;
         m_bd    = '0;
      end else begin
         sz   = mq.size();
         want = m_burst || (m_pkts != 0);
         g    = gnt_auto ? want : gnt_man;
         pu   = bif.in_valid && (sz < DEPTH);
         po   = want && g;
         if (sz == DEPTH && m_pkts == 0) m_err = 1'b1;
         m_bv = po;
         if (po) begin
            b       = mq.pop_front();
            m_bd    = b[DW-1:0];
            m_bl    = b[DW];
            m_burst = !b[DW];
            if (b[DW]) m_pkts--;
         end
         if (pu) begin
            mq.push_back({bif.in_last, bif.in_data});
            if (bif.in_last) m_pkts++;
         end
      end
   end

   // Compare process: every output against the model on each falling edge.
   bit cmp_en = 1'b0;
   always @(negedge clk) begin
      if (cmp_en) begin
         chk("in_ready",  bif.in_ready,     mq.size() < DEPTH);
         chk("req",       bif.req,          m_burst || (m_pkts != 0));
         chk("hold",      bif.hold,         m_burst);
         chk("bus_valid", bif.bus_valid,    m_bv);
         chk("bus_data",  bif.bus_data,     m_bd);
         chk("bus_last",  bif.bus_last,     m_bl);
         chk("fill",      bif.fill,         mq.size());
         chk("err",       bif.err_deadlock, m_err);
      end
   end

   task automatic step(input bit v, input logic [DW-1:0] d, input bit l, input bit g);
      bif.in_valid = v;
      bif.in_data  = d;
      bif.in_last  = l;
      gnt_man      = g;
      @(posedge clk);
      #2;
   endtask

   initial begin
      int cur_len;
      int guard;
      bit v, l;
      logic [DW-1:0] d;

      bif.in_valid = 1'b0;
      bif.in_data  = '0;
      bif.in_last  = 1'b0;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_req",   bif.req, 0);
      chk("rst_fill",  bif.fill, 0);
      chk("rst_bv",    bif.bus_valid, 0);
      chk("rst_err",   bif.err_deadlock, 0);
      rst_b  = 1'b1;
      cmp_en = 1'b1;
      step(0, 0, 0, 0);
      chk("rst_in_ready", bif.in_ready, 1);

      // Single-beat packet with gnt tied to req.
      gnt_auto = 1'b1;
      step(1, 32'hA5, 1, 0);
      chk("p1_req", bif.req, 1);
      chk("p1_hold", bif.hold, 0);
      step(0, 0, 0, 0);
      chk("p1_bv", bif.bus_valid, 1);
      chk("p1_data", bif.bus_data, 32'hA5);
      chk("p1_last", bif.bus_last, 1);
      chk("p1_hold2", bif.hold, 0);
      chk("p1_fill", bif.fill, 0);
      gnt_auto = 1'b0;
      step(0, 0, 0, 0);

      // Four-beat packet, gnt held.
      for (int i = 0; i < 4; i++) step(1, 32'h10 + i, i == 3, 0);
      chk("p4_req", bif.req, 1);
      chk("p4_fill", bif.fill, 4);
      for (int i = 0; i < 4; i++) begin
         step(0, 0, 0, 1);
         chk("p4_bv", bif.bus_valid, 1);
         chk("p4_data", bif.bus_data, 32'h10 + i);
         chk("p4_last", bif.bus_last, i == 3);
         chk("p4_hold", bif.hold, i < 3);
      end
      step(0, 0, 0, 0);
      chk("p4_idle_bv", bif.bus_valid, 0);
      chk("p4_idle_req", bif.req, 0);

      // Partial packet: no req until the last beat lands; then a 2-cycle grant drop.
      for (int i = 0; i < 3; i++) step(1, 32'h20 + i, 0, 1);
      repeat (5) step(0, 0, 0, 1);
      chk("part_req", bif.req, 0);
      chk("part_fill", bif.fill, 3);
      step(1, 32'h23, 1, 0);
      chk("part_req2", bif.req, 1);
      step(0, 0, 0, 1);
      chk("stall_d0", bif.bus_data, 32'h20);
      for (int i = 0; i < 2; i++) begin
         step(0, 0, 0, 0);
         chk("stall_bv", bif.bus_valid, 0);
         chk("stall_req", bif.req, 1);
         chk("stall_hold", bif.hold, 1);
         chk("stall_fill", bif.fill, 3);
      end
      for (int i = 1; i < 4; i++) begin
         step(0, 0, 0, 1);
         chk("resume_bv", bif.bus_valid, 1);
         chk("resume_data", bif.bus_data, 32'h20 + i);
      end
      chk("resume_last", bif.bus_last, 1);
      step(0, 0, 0, 0);

      // Two 2-beat packets back-to-back with overlapping push/pop.
      gnt_auto = 1'b1;
      step(1, 32'h30, 0, 0);
      step(1, 32'h31, 1, 0);
      step(1, 32'h40, 0, 0);
      step(1, 32'h41, 1, 0);
      chk("b2b_last", bif.bus_last, 1);
      chk("b2b_data", bif.bus_data, 32'h31);
      chk("b2b_req", bif.req, 1);
      chk("b2b_hold", bif.hold, 0);
      chk("b2b_fill", bif.fill, 2);
      step(0, 0, 0, 0);
      step(0, 0, 0, 0);
      chk("b2b_d2", bif.bus_data, 32'h41);
      chk("b2b_fill2", bif.fill, 0);
      gnt_auto = 1'b0;

      // Random traffic, packets capped at DEPTH beats, random (possibly absent) grants.
      cur_len = 0;
      repeat (1500) begin
         v = ($urandom % 3) != 0;
         d = $urandom;
         l = 1'b0;
         if (v && bif.in_ready) begin
            cur_len++;
            l = (cur_len == DEPTH) || (($urandom % 4) == 0);
            if (l) cur_len = 0;
         end
         step(v, d, l, ($urandom % 4) != 0);
      end
      guard = 0;
      while (cur_len > 0 && guard < 50) begin
         if (bif.in_ready) begin
            step(1, $urandom, 1, 1);
            cur_len = 0;
         end else begin
            step(0, 0, 0, 1);
         end
         guard++;
      end
      guard = 0;
      while (bif.fill != 0 && guard < 100) begin
         step(0, 0, 0, 1);
         guard++;
      end
      chk("drain_fill", bif.fill, 0);

      // Deadlock: a packet longer than the buffer.
      for (int i = 0; i < DEPTH; i++) step(1, 32'h50 + i, 0, 1);
      chk("dl_in_ready", bif.in_ready, 0);
      chk("dl_fill", bif.fill, DEPTH);
      step(1, 32'h99, 1, 1);
      chk("dl_err", bif.err_deadlock, 1);
      chk("dl_fill2", bif.fill, DEPTH);
      repeat (3) step(0, 0, 0, 1);
      chk("dl_err_sticky", bif.err_deadlock, 1);
      chk("dl_req", bif.req, 0);

      // Asynchronous reset clears everything.
      rst_b = 1'b0;
      #1;
      chk("ar_err", bif.err_deadlock, 0);
      chk("ar_fill", bif.fill, 0);
      chk("ar_req", bif.req, 0);
      chk("ar_bv", bif.bus_valid, 0);
      chk("ar_bd", bif.bus_data, 0);
      chk("ar_bl", bif.bus_last, 0);
      step(0, 0, 0, 0);
      rst_b = 1'b1;
      step(0, 0, 0, 0);
      chk("ar_in_ready", bif.in_ready, 1);
      step(0, 0, 0, 0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule
